tank_sprite_fetch: RTL
======================

# tank_sprite_fetch

Per-pixel fetch engine that drives the tank sprite ROM's `read_address`, consumes its registered 24-bit colour output, and produces a colour-keyed, pipeline-aligned tank pixel for the colour mapper. Sits between the VGA scan counters (`DrawX`/`DrawY`) and the tank sprite ROM. It owns bounding-box test, orientation-dependent address generation, ROM latency alignment and a hit-flash state machine.

## Interface
- `SPRITE_W`, 50, sprite width in pixels
- `SPRITE_H`, 50, sprite height in pixels (must equal `SPRITE_W` when rotation compiled in)
- `ADDR_W`, 19, ROM address width
- `KEY_COLOR`, 24'hFF0000, transparent colour (palette entry 0)
- `FLASH_FRAMES`, 60, frames of flashing after a hit
- `BLINK_BIT`, 2, bit of flash counter that blanks the sprite when 1

- `Clk`  in  1  system clock; single clock domain
- `Reset_n`  in  1  asynchronous, active-low reset
- `pixel_en`  in  1  current `DrawX`/`DrawY` valid this cycle
- `frame_start`  in  1  one-cycle pulse at start of each frame
- `DrawX`, `DrawY`  in  10 each  current scan position
- `TankX`, `TankY`  in  10 each  sprite top-left corner
- `dir`  in  2  orientation: 0 up, 1 right, 2 down, 3 left
- `hit_pulse`  in  1  one-cycle pulse: tank was hit
- `read_address`  out  ADDR_W  to sprite ROM
- `rom_data`  in  24  ROM `data_Out` (valid 2 cycles after address)
- `pixel_rgb`  out  24  tank colour
- `pixel_hit`  out  1  tank pixel opaque and visible
- `pixel_valid`  out  1  `pixel_en` delayed to align with `pixel_rgb`
- `flashing`  out  1  flash state active

## Operation
- Stage 0 (comb, registered into `read_address`): `rx = DrawX - TankX`, `ry = DrawY - TankY` in 11-bit signed; `in_box = 0<=rx<SPRITE_W && 0<=ry<SPRITE_H`.
- Source coordinates by `dir`: 0 `(rx,ry)`; 1 `(ry, W-1-rx)`; 2 `(W-1-rx, H-1-ry)`; 3 `(H-1-ry, rx)`. Address = `sy*SPRITE_W + sx`, range 0..2499, zero-extended to `ADDR_W`.
- Outside the box: `read_address` holds 0; the in-box flag is carried as 0.
- `in_box` and `pixel_en` travel through a 3-deep shift register aligned with the ROM's two register stages; pipeline advances every `Clk`, no stall.
- Output: `pixel_hit = in_box_d && rom_data != KEY_COLOR && !blank`; `pixel_rgb = pixel_hit ? rom_data : 0`.
- FSM states NORMAL, FLASH. Counter width `$clog2(FLASH_FRAMES+1)`.
  - NORMAL + `hit_pulse` -> FLASH, counter = `FLASH_FRAMES`.
  - FLASH + `hit_pulse` -> counter reloaded (reload beats simultaneous `frame_start` decrement).
  - FLASH + `frame_start` -> counter - 1; at counter 1 -> NORMAL, counter 0.
  - `blank = FLASH && counter[BLINK_BIT]`. `flashing = (state == FLASH)`.
- Blanking is sampled at output time; a mid-frame state change takes effect immediately.

## Timing
- Reset: `read_address` 0, `pixel_rgb` 0, `pixel_hit` 0, `pixel_valid` 0, `flashing` 0, state NORMAL, counter 0, pipeline flags 0.
- `read_address` registered: 1 cycle after inputs. `pixel_rgb`/`pixel_hit`/`pixel_valid`: 3 cycles after inputs (1 here + 2 ROM).
- Reset mid-line: outputs clear asynchronously; first valid output 3 cycles after release.
- Wrap-around: negative `rx`/`ry` (tank partly off-left/top) must be rejected; `TankX+SPRITE_W > 639` simply clips.
- `dir` or `TankX/TankY` changes mid-frame apply from the next sampled pixel.

## Configuration
- `TANK_SPRITE_ROTATE_EN` defined: four-orientation mapping as above.
- Undefined: `dir` ignored, address always `ry*SPRITE_W + rx`; `SPRITE_H` may differ from `SPRITE_W`.

## Structure
- Shared package `tank_pkg`: `dir_t` enum (UP, RIGHT, DOWN, LEFT), `flash_state_t` enum, `TANK_SPRITE_W/H`, `TANK_KEY_COLOR`.
- One sub-module: `tank_addr_gen` (combinational bounding box + rotation + multiply-add). FSM and latency pipeline stay in the top.

## Test plan
- Tank at (100,100), dir 0, scan (100,100) then (149,149) -> `read_address` 0 then 2499 one cycle later; `pixel_valid` 3 cycles after.
- dir 1, scan (100,100) -> address `49*50 + 0` = 2450; dir 3 -> 49; dir 2 -> 2499 (rotation macro on); macro off -> 0 for all dirs.
- Scan (99,120) and (150,120) with tank at (100,100) -> `pixel_hit` 0, `pixel_rgb` 0; ROM returns 24'hFF0000 in-box -> `pixel_hit` 0.
- `hit_pulse` then 60 `frame_start` pulses -> `flashing` 1 for 60 frames, 0 after 60th; sprite blanked on frames where counter bit 2 set.
- `hit_pulse` coincident with `frame_start` at counter 10 -> counter 60, not 9.
- Assert `Reset_n` low mid-scan with `pixel_hit` 1 -> all outputs 0 immediately; state NORMAL after release.

Source files
------------

// File: rtl/tank_pkg.sv
// rtl/tank_pkg.sv - shared types and default geometry for the tank sprite fetch path
package tank_pkg;

  localparam int          TANK_SPRITE_W  = 50;
  localparam int          TANK_SPRITE_H  = 50;
  localparam logic [23:0] TANK_KEY_COLOR = 24'hFF0000;

  typedef enum logic [1:0] {UP, RIGHT, DOWN, LEFT} dir_t;
  typedef enum logic {NORMAL, FLASH} flash_state_t;

endpackage

// File: rtl/tank_addr_gen.sv
// rtl/tank_addr_gen.sv - bounding box test and sprite ROM address, orientation honoured under TANK_SPRITE_ROTATE_EN
module tank_addr_gen
  import tank_pkg::*;
#(
  parameter int SPRITE_W = TANK_SPRITE_W,
  parameter int SPRITE_H = TANK_SPRITE_H,
  parameter int ADDR_W   = 19
) (
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [9:0]        tank_x,
  input  logic [9:0]        tank_y,
  input  dir_t              dir,
  output logic              in_box,
  output logic [ADDR_W-1:0] addr
);

  logic signed [10:0] rx, ry;
  logic [9:0]         ux, uy, sx, sy;

  // 11-bit signed difference so a tank hanging off the left/top edge gives a negative offset
  assign rx = $signed({1'b0, draw_x}) - $signed({1'b0, tank_x});
  assign ry = $signed({1'b0, draw_y}) - $signed({1'b0, tank_y});
  assign ux = rx[9:0];
  assign uy = ry[9:0];

  assign in_box = !rx[10] && !ry[10] && (ux < 10'(SPRITE_W)) && (uy < 10'(SPRITE_H));

`ifdef TANK_SPRITE_ROTATE_EN
  always_comb begin
    sx = ux;
    sy = uy;
    case (dir)
      UP:    begin sx = ux;                      sy = uy;                      end
      RIGHT: begin sx = uy;                      sy = 10'(SPRITE_W - 1) - ux;  end
      DOWN:  begin sx = 10'(SPRITE_W - 1) - ux;  sy = 10'(SPRITE_H - 1) - uy;  end
      LEFT:  begin sx = 10'(SPRITE_H - 1) - uy;  sy = ux;                      end
      default: ;
    endcase
  end
`else
  logic unused_dir;
  assign unused_dir = ^dir;
  assign sx = ux;
  assign sy = uy;
`endif

  assign addr = in_box ? (ADDR_W'(sy) * ADDR_W'(SPRITE_W) + ADDR_W'(sx)) : '0;

endmodule

// File: rtl/tank_sprite_fetch.sv
// rtl/tank_sprite_fetch.sv - per-pixel tank sprite fetch with ROM latency alignment and hit flash
// Rotation support is compiled in with TANK_SPRITE_ROTATE_EN.
module tank_sprite_fetch
  import tank_pkg::*;
#(
  parameter int          SPRITE_W     = TANK_SPRITE_W,
  parameter int          SPRITE_H     = TANK_SPRITE_H,
  parameter int          ADDR_W       = 19,
  parameter logic [23:0] KEY_COLOR    = TANK_KEY_COLOR,
  parameter int          FLASH_FRAMES = 60,
  parameter int          BLINK_BIT    = 2
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              pixel_en,
  input  logic              frame_start,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [9:0]        TankX,
  input  logic [9:0]        TankY,
  input  logic [1:0]        dir,
  input  logic              hit_pulse,
  output logic [ADDR_W-1:0] read_address,
  input  logic [23:0]       rom_data,
  output logic [23:0]       pixel_rgb,
  output logic              pixel_hit,
  output logic              pixel_valid,
  output logic              flashing
);

  localparam int CW = $clog2(FLASH_FRAMES + 1);

  logic              in_box;
  logic [ADDR_W-1:0] addr_next;
  logic [2:0]        in_box_sr, valid_sr;
  flash_state_t      state;
  logic [CW-1:0]     cnt;
  logic              blank;

  tank_addr_gen #(
    .SPRITE_W (SPRITE_W),
    .SPRITE_H (SPRITE_H),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .tank_x (TankX),
    .tank_y (TankY),
    .dir    (dir_t'(dir)),
    .in_box (in_box),
    .addr   (addr_next)
  );

  // Stage 0 registers the address; the flags then ride two more stages to meet the ROM output
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      read_address <= '0;
      in_box_sr    <= '0;
      valid_sr     <= '0;
    end else begin
      read_address <= addr_next;
      in_box_sr    <= {in_box_sr[1:0], in_box};
      valid_sr     <= {valid_sr[1:0], pixel_en};
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= NORMAL;
      cnt   <= '0;
    end else begin
      case (state)
        NORMAL: if (hit_pulse) begin
          state <= FLASH;
          cnt   <= CW'(FLASH_FRAMES);
        end
        FLASH: if (hit_pulse) begin
          cnt <= CW'(FLASH_FRAMES);
        end else if (frame_start) begin
          if (cnt == CW'(1)) begin
            state <= NORMAL;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= NORMAL;
      endcase
    end
  end

  // Blank is evaluated at output time so a state change lands on the very next output pixel
  assign blank       = (state == FLASH) && cnt[BLINK_BIT];
  assign pixel_hit   = in_box_sr[2] && (rom_data != KEY_COLOR) && !blank;
  assign pixel_rgb   = pixel_hit ? rom_data : 24'h0;
  assign pixel_valid = valid_sr[2];
  assign flashing    = (state == FLASH);

endmodule
